kmkz_fetch_buffer: RTL



---
 rtl/kmkz_pkg.sv | 10 +
 rtl/kmkz_fetch_align.sv | 37 +++
 rtl/kmkz_fetch_buffer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/kmkz_pkg.sv
// Shared constants for the kmkz instruction fetch path.
package kmkz_pkg;

  // Low two bits of a parcel equal to this mark a 32-bit instruction.
  localparam logic [1:0]  OPC_32      = 2'b11;
  localparam int          ILEN        = 32;
  localparam logic [31:0] PC_INC_HALF = 32'd2;
  localparam logic [31:0] PC_INC_WORD = 32'd4;

endpackage

// File: rtl/kmkz_fetch_align.sv
// Extracts the instruction at halfword pointer rp from the word buffer and
// reports whether all of its halfwords are present.
module kmkz_fetch_align
  import kmkz_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter bit RVC_EN = 1'b1,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic [ILEN-1:0] words [DEPTH],
  input  logic [CW-1:0]   rp,
  input  logic [CW-1:0]   count,
  output logic [ILEN-1:0] instr,
  output logic            compressed,
  output logic            need_two,
  output logic            complete
);

  logic [AW-1:0] e0;
  logic [AW-1:0] e1;
  logic [15:0]   lo;
  logic [15:0]   hi;

  always_comb begin
    e0 = rp[CW-1:1];
    e1 = e0 + AW'(1);
    lo = rp[0] ? words[e0][31:16] : words[e0][15:0];
    // An odd head pointer takes the upper parcel half from the next entry.
    hi = rp[0] ? words[e1][15:0] : words[e0][31:16];
    compressed = RVC_EN && (lo[1:0] != OPC_32);
    need_two   = !compressed && rp[0];
    complete   = need_two ? (count >= CW'(2)) : (count != '0);
    instr      = compressed ? {16'h0000, lo} : {hi, lo};
  end

endmodule

// File: rtl/kmkz_fetch_buffer.sv
// RVC-aware fetch buffer: credit-limited word fetch over a req/gnt/rvalid bus,
// halfword realignment and a show-ahead valid/ready instruction port.
module kmkz_fetch_buffer
  import kmkz_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter bit          RVC_EN   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_compressed_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [31:0] PC_MASK = RVC_EN ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;

  logic [ILEN-1:0] buf_q [DEPTH];
  logic [AW-1:0]   wp_q;
  logic [CW-1:0]   rp_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   outst_q;
  logic [CW-1:0]   drop_q;
  logic [31:0]     fetch_addr_q;
  logic [31:0]     pc_q;

  logic [ILEN-1:0] al_instr;
  logic            al_comp;
  logic            al_need_two;
  logic            al_complete;
  logic [CW:0]     credit_used;
  logic [CW-1:0]   pop_cnt;
  logic [CW-1:0]   outst_next;
  logic            gnt;
  logic            push;
  logic            pop;

  kmkz_fetch_align #(.DEPTH(DEPTH), .RVC_EN(RVC_EN)) u_align (
    .words      (buf_q),
    .rp         (rp_q),
    .count      (cnt_q),
    .instr      (al_instr),
    .compressed (al_comp),
    .need_two   (al_need_two),
    .complete   (al_complete)
  );

  // Outstanding requests hold a buffer slot, so a response always has room.
  assign credit_used = {1'b0, cnt_q} + {1'b0, outst_q};
  assign mem_req_o   = (credit_used < (CW+1)'(DEPTH)) && (drop_q == '0) && rst_i;
  assign mem_addr_o  = fetch_addr_q;
  assign gnt         = mem_req_o && mem_gnt_i;
  assign push        = mem_rvalid_i && (drop_q == '0);
  assign outst_next  = outst_q + CW'(gnt) - CW'(mem_rvalid_i);

  // Decode handshake: an instruction transfers on a cycle with instr_valid_o
  // and instr_ready_i both high; while valid waits for ready, the output holds.
  assign instr_valid_o      = al_complete;
  assign instr_o            = al_instr;
  assign instr_pc_o         = pc_q;
  assign instr_compressed_o = al_complete && al_comp;
  assign pop                = instr_valid_o && instr_ready_i;
  // Only a compressed parcel in the low half leaves the head entry occupied.
  assign pop_cnt            = (al_comp && !rp_q[0]) ? '0 : CW'(1);

  always_ff @(posedge clk_i) begin
    if (push && !redirect_i && rst_i) begin
      buf_q[wp_q] <= mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wp_q         <= '0;
      rp_q         <= {{AW{1'b0}}, RESET_PC[1] & RVC_EN};
      cnt_q        <= '0;
      outst_q      <= '0;
      drop_q       <= '0;
      fetch_addr_q <= RESET_PC & 32'hFFFF_FFFC;
      pc_q         <= RESET_PC & PC_MASK;
    end else if (redirect_i) begin
      // Everything still in flight, including this cycle's grant, is stale.
      wp_q         <= '0;
      rp_q         <= {{AW{1'b0}}, redirect_pc_i[1] & RVC_EN};
      cnt_q        <= '0;
      outst_q      <= outst_next;
      drop_q       <= outst_next;
      fetch_addr_q <= redirect_pc_i & 32'hFFFF_FFFC;
      pc_q         <= redirect_pc_i & PC_MASK;
    end else begin
      if (gnt) begin
        fetch_addr_q <= fetch_addr_q + PC_INC_WORD;
      end
      if (push) begin
        wp_q <= wp_q + AW'(1);
      end
      if (pop) begin
        rp_q <= rp_q + (al_comp ? CW'(1) : CW'(2));
        pc_q <= pc_q + (al_comp ? PC_INC_HALF : PC_INC_WORD);
      end
      if (mem_rvalid_i && (drop_q != '0)) begin
        drop_q <= drop_q - CW'(1);
      end
      cnt_q   <= cnt_q + CW'(push) - (pop ? pop_cnt : '0);
      outst_q <= outst_next;
    end
  end

  // A straddling instruction is only issued with both of its entries present.
  always_ff @(posedge clk_i) begin
    if (rst_i && pop) begin
      assert (!al_need_two || (cnt_q >= CW'(2)));
    end
  end

endmodule
